lvds_rx_word_align: RTL and testbench



---
 rtl/lvds_rx_word_align.sv | 215 +++++++++++++++++++++
 tb/tb_lvds_rx_word_align.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_rx_word_align.sv
// ---------------------------------------------------------------------------
// lvds_rx_word_align
//
// Word-alignment controller for a 7:1 LVDS receive path, clocked by sclk
// directly behind the deserialisers. It pulses `slip` until the clock-lane
// word matches CLK_PATTERN. It then qualifies lock over LOCK_CNT consecutive
// good words and presents registered, valid-flagged pixel data. It
// re-aligns by itself after repeated pattern errors or after PLL loss.
//
// Parameters
//   LANES        data lanes per channel (3 = RGB666, 4 = RGB888)
//   CHANNELS     1 = single, 2 = odd/even dual channel
//   CLK_PATTERN  clock-lane word expected once aligned
//   SETTLE_CYC   cycles waited after PLL lock before the first check (>=1)
//   SLIP_GAP     idle cycles after each slip before the next check (>=1)
//   LOCK_CNT     consecutive matching words that declare alignment (>=2)
//   ERR_MAX      consecutive mismatches in ALIGNED forcing re-alignment (>=1)
//
// Ports
//   sclk        pixel clock, all logic on its rising edge
//   reset       synchronous, active-high
//   pll_lock    asynchronous PLL lock, synchronised internally (2 flops)
//   clk_phase   deserialised clock-lane word
//   rx_data     deserialised lane words, lane k at [7k+6:7k], channel 0 low
//   slip        one-cycle bit-slip pulse to all deserialisers
//   aligned     high while in ALIGNED
//   align_err   sticky: 7 slips did not find the pattern; cleared by reset
//   slip_cnt    slips applied since the last PLL lock, modulo 7
//   data_out    rx_data delayed one cycle while aligned, otherwise 0
//   data_valid  qualifies data_out
// ---------------------------------------------------------------------------
module lvds_rx_word_align #(
    parameter int unsigned LANES       = 4,
    parameter int unsigned CHANNELS    = 1,
    parameter logic [6:0]  CLK_PATTERN = 7'b1100011,
    parameter int unsigned SETTLE_CYC  = 64,
    parameter int unsigned SLIP_GAP    = 16,
    parameter int unsigned LOCK_CNT    = 256,
    parameter int unsigned ERR_MAX     = 4
) (
    input  logic                        sclk,
    input  logic                        reset,
    input  logic                        pll_lock,
    input  logic [6:0]                  clk_phase,
    input  logic [CHANNELS*LANES*7-1:0] rx_data,
    output logic                        slip,
    output logic                        aligned,
    output logic                        align_err,
    output logic [2:0]                  slip_cnt,
    output logic [CHANNELS*LANES*7-1:0] data_out,
    output logic                        data_valid
);

    // Counter widths: each counter holds values up to its limit.
    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned GAP_W    = $clog2(SLIP_GAP + 1);
    localparam int unsigned GOOD_W   = $clog2(LOCK_CNT + 1);
    localparam int unsigned ERR_W    = $clog2(ERR_MAX + 1);
    localparam int unsigned ATT_MAX  = 7;
    localparam int unsigned ATT_W    = $clog2(ATT_MAX + 1);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(SLIP_GAP - 1);
    localparam logic [GOOD_W-1:0]   GOOD_LAST   = GOOD_W'(LOCK_CNT - 1);
    localparam logic [ERR_W-1:0]    ERR_LAST    = ERR_W'(ERR_MAX - 1);
    localparam logic [ATT_W-1:0]    ATT_LAST    = ATT_W'(ATT_MAX);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        SETTLE,
        CHECK,
        SLIP,
        GAP,
        VERIFY,
        ALIGNED
    } state_t;

    state_t              state;
    logic                lock_meta;
    logic                lock_sync;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [GOOD_W-1:0]   good_cnt;
    logic [ERR_W-1:0]    err_cnt;
    logic [ATT_W-1:0]    attempt_cnt;
    logic                phase_match;

    assign phase_match = (clk_phase == CLK_PATTERN);

    // Lock synchroniser, alignment FSM and registered outputs.
    // Pulse-style outputs default low each cycle; the states that keep
    // them high (SLIP entry, ALIGNED entry/hold) re-assert them.
    always_ff @(posedge sclk) begin
        if (reset) begin
            state       <= WAIT_LOCK;
            lock_meta   <= 1'b0;
            lock_sync   <= 1'b0;
            settle_cnt  <= '0;
            gap_cnt     <= '0;
            good_cnt    <= '0;
            err_cnt     <= '0;
            attempt_cnt <= '0;
            slip        <= 1'b0;
            aligned     <= 1'b0;
            align_err   <= 1'b0;
            slip_cnt    <= 3'd0;
            data_out    <= '0;
            data_valid  <= 1'b0;
        end else begin
            lock_meta  <= pll_lock;
            lock_sync  <= lock_meta;

            slip       <= 1'b0;
            aligned    <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= '0;

            if (state != WAIT_LOCK && !lock_sync) begin
                // PLL loss wins over every other transition.
                state       <= WAIT_LOCK;
                slip_cnt    <= 3'd0;
                settle_cnt  <= '0;
                gap_cnt     <= '0;
                good_cnt    <= '0;
                err_cnt     <= '0;
                attempt_cnt <= '0;
            end else begin
                case (state)
                    WAIT_LOCK: begin
                        if (lock_sync) begin
                            state      <= SETTLE;
                            settle_cnt <= '0;
                        end
                    end

                    SETTLE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state       <= CHECK;
                            settle_cnt  <= '0;
                            attempt_cnt <= '0;
                        end else begin
                            settle_cnt <= settle_cnt + SETTLE_W'(1);
                        end
                    end

                    CHECK: begin
                        if (phase_match) begin
                            state    <= VERIFY;
                            good_cnt <= '0;
                        end else if (attempt_cnt == ATT_LAST) begin
                            // Every rotation tried without success.
                            align_err   <= 1'b1;
                            attempt_cnt <= '0;
                            settle_cnt  <= '0;
                            state       <= SETTLE;
                        end else begin
                            state <= SLIP;
                            slip  <= 1'b1;
                        end
                    end

                    SLIP: begin
                        slip_cnt    <= (slip_cnt == 3'd6) ? 3'd0 : slip_cnt + 3'd1;
                        attempt_cnt <= attempt_cnt + ATT_W'(1);
                        gap_cnt     <= '0;
                        state       <= GAP;
                    end

                    GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state   <= CHECK;
                            gap_cnt <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end

                    VERIFY: begin
                        if (!phase_match) begin
                            // Attempt count survives so a flaky lane still ends in align_err.
                            state <= CHECK;
                        end else begin
                            good_cnt <= good_cnt + GOOD_W'(1);
                            if (good_cnt == GOOD_LAST) begin
                                state      <= ALIGNED;
                                err_cnt    <= '0;
                                aligned    <= 1'b1;
                                data_valid <= 1'b1;
                                data_out   <= rx_data;
                            end
                        end
                    end

                    ALIGNED: begin
                        if (!phase_match && err_cnt == ERR_LAST) begin
                            state       <= CHECK;
                            err_cnt     <= '0;
                            attempt_cnt <= '0;
                        end else begin
                            err_cnt    <= phase_match ? '0 : err_cnt + ERR_W'(1);
                            aligned    <= 1'b1;
                            data_valid <= 1'b1;
                            data_out   <= rx_data;
                        end
                    end

                    default: begin
                        state <= WAIT_LOCK;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lvds_rx_word_align.sv
// ---------------------------------------------------------------------------
// tb_lvds_rx_word_align
//
// Two instances share the control inputs: u0 (1 channel x 4 lanes, 28 bits)
// and u1 (2 channels x 3 lanes, 42 bits). The clock-lane model rotates
// clk_phase left by one bit on every slip from u0. Expected slip times and
// expected pixel words go into queues; monitor processes pop and compare.
// Event times are counted in sclk rising edges from the edge that first
// samples pll_lock = 1: two synchroniser edges, one WAIT_LOCK exit, then
// SETTLE(8) + CHECK(1) + VERIFY(16), and 6 more per slip.
// ---------------------------------------------------------------------------
module tb_lvds_rx_word_align;

    localparam logic [6:0] PAT   = 7'b1100011;
    localparam logic [6:0] ROT3  = 7'b0111100;   // PAT rotated right by 3
    localparam logic [6:0] ROT1  = 7'b1110001;   // PAT rotated right by 1

    logic        sclk = 1'b0;
    logic        reset = 1'b1;
    logic        pll_lock = 1'b0;
    logic [6:0]  clk_phase;
    logic [27:0] rx0 = '0;
    logic [41:0] rx1 = '0;
    logic        slip0, aligned0, err0, dv0;
    logic        slip1, aligned1, err1, dv1;
    logic [2:0]  scnt0, scnt1;
    logic [27:0] dout0;
    logic [41:0] dout1;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Clock-lane model
    int         rot = 0;
    logic       rot_clr = 1'b1;
    logic [6:0] base = PAT;
    logic       force_bad = 1'b0;

    typedef struct {
        int          stamp;
        logic [27:0] d0;
        logic [41:0] d1;
    } dvec_t;

    dvec_t dq[$];
    int    sq[$];

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    function automatic logic [6:0] rol(input logic [6:0] w, input int n);
        logic [6:0] r;
        r = w;
        for (int i = 0; i < n; i++) r = {r[5:0], r[6]};
        return r;
    endfunction

    always @(posedge sclk) begin
        if (rot_clr)    rot <= 0;
        else if (slip0) rot <= (rot == 6) ? 0 : rot + 1;
    end

    assign clk_phase = force_bad ? 7'h00 : rol(base, rot);

    lvds_rx_word_align #(
        .LANES(4), .CHANNELS(1), .CLK_PATTERN(PAT),
        .SETTLE_CYC(8), .SLIP_GAP(4), .LOCK_CNT(16), .ERR_MAX(4)
    ) u0 (
        .sclk(sclk), .reset(reset), .pll_lock(pll_lock), .clk_phase(clk_phase),
        .rx_data(rx0), .slip(slip0), .aligned(aligned0), .align_err(err0),
        .slip_cnt(scnt0), .data_out(dout0), .data_valid(dv0)
    );

    lvds_rx_word_align #(
        .LANES(3), .CHANNELS(2), .CLK_PATTERN(PAT),
        .SETTLE_CYC(8), .SLIP_GAP(4), .LOCK_CNT(16), .ERR_MAX(4)
    ) u1 (
        .sclk(sclk), .reset(reset), .pll_lock(pll_lock), .clk_phase(clk_phase),
        .rx_data(rx1), .slip(slip1), .aligned(aligned1), .align_err(err1),
        .slip_cnt(scnt1), .data_out(dout1), .data_valid(dv1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic at(input int t);
        while (cyc < t) @(negedge sclk);
    endtask

    // Status of both instances against one bench expectation.
    task automatic chk_status(input string name, input logic al, input logic [2:0] sc, input logic er);
        check({name, " aligned0"}, aligned0, al);
        check({name, " aligned1"}, aligned1, al);
        check({name, " slip_cnt0"}, scnt0, sc);
        check({name, " slip_cnt1"}, scnt1, sc);
        check({name, " align_err0"}, err0, er);
        check({name, " align_err1"}, err1, er);
    endtask

    task automatic start(input logic [6:0] b, input logic bad, output int l);
        @(negedge sclk);
        reset = 1'b1; pll_lock = 1'b0; rot_clr = 1'b1; base = b; force_bad = bad;
        repeat (3) @(negedge sclk);
        reset = 1'b0; rot_clr = 1'b0;
        @(negedge sclk);
        l = cyc;
        pll_lock = 1'b1;
    endtask

    // Pixel driver: distinct word per lane and per cycle, pushed with its stamp.
    initial begin
        forever begin
            dvec_t e;
            @(posedge sclk);
            #2;
            e.stamp = cyc;
            e.d0 = '0;
            e.d1 = '0;
            for (int k = 0; k < 4; k++) e.d0[7*k +: 7] = 7'(cyc * 5 + k * 19);
            for (int k = 0; k < 6; k++) e.d1[7*k +: 7] = 7'(cyc * 3 + k * 21 + 40);
            rx0 = e.d0;
            rx1 = e.d1;
            dq.push_back(e);
        end
    end

    // Data monitor: valid output must be the word driven one edge earlier.
    initial begin
        forever begin
            @(negedge sclk);
            while (dq.size() > 0 && dq[0].stamp < cyc - 1) void'(dq.pop_front());
            if (dv0) check("data_out0", dout0, (dq.size() > 0) ? dq[0].d0 : 'x);
            else     check("data_out0 idle", dout0, 0);
            if (dv1) check("data_out1", dout1, (dq.size() > 0) ? dq[0].d1 : 'x);
            else     check("data_out1 idle", dout1, 0);
        end
    end

    // Slip monitor: a slip is expected exactly at the queued cycles.
    initial begin
        forever begin
            logic exp_slip;
            @(negedge sclk);
            exp_slip = (sq.size() > 0 && sq[0] == cyc);
            check("slip0", slip0, exp_slip);
            check("slip1", slip1, exp_slip);
            if (exp_slip) void'(sq.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l;

        // Correct pattern at lock: 25 edges after WAIT_LOCK exit.
        start(PAT, 1'b0, l);
        chk_status("reset state", 1'b0, 3'd0, 1'b0);
        check("reset data_valid0", dv0, 1'b0);
        check("reset data_valid1", dv1, 1'b0);
        at(l + 27); chk_status("t1 before lock", 1'b0, 3'd0, 1'b0);
        at(l + 28); chk_status("t1 aligned", 1'b1, 3'd0, 1'b0);
        check("t1 data_valid0", dv0, 1'b1);
        check("t1 data_valid1", dv1, 1'b1);
        at(l + 40);

        // Pattern rotated by 3: three slips 6 cycles apart.
        start(ROT3, 1'b0, l);
        sq.push_back(l + 12); sq.push_back(l + 18); sq.push_back(l + 24);
        at(l + 45); chk_status("t2 before lock", 1'b0, 3'd3, 1'b0);
        at(l + 46); chk_status("t2 aligned", 1'b1, 3'd3, 1'b0);
        check("t2 slips pending", sq.size(), 0);

        // Stuck word: seven slips, align_err, then a good word aligns.
        start(PAT, 1'b1, l);
        for (int i = 0; i < 7; i++) sq.push_back(l + 12 + 6 * i);
        at(l + 53); chk_status("t3 before err", 1'b0, 3'd0, 1'b0);
        at(l + 54); chk_status("t3 align_err", 1'b0, 3'd0, 1'b1);
        at(l + 56); force_bad = 1'b0;
        at(l + 78); chk_status("t3 before lock", 1'b0, 3'd0, 1'b1);
        at(l + 79); chk_status("t3 aligned", 1'b1, 3'd0, 1'b1);
        check("t3 slips pending", sq.size(), 0);
        // PLL blip out of ALIGNED, then reset while re-verifying.
        at(l + 85); pll_lock = 1'b0;
        at(l + 86); pll_lock = 1'b1;
        at(l + 87); chk_status("t3 pll blip held", 1'b1, 3'd0, 1'b1);
        at(l + 88); chk_status("t3 pll blip drop", 1'b0, 3'd0, 1'b1);
        at(l + 100); reset = 1'b1;
        at(l + 101); chk_status("t3 reset in verify", 1'b0, 3'd0, 1'b0);
        check("t3 reset data_valid0", dv0, 1'b0);
        check("t3 reset data_out1", dout1, 0);

        // ALIGNED error handling: 3 bad words tolerated, 4 force re-alignment.
        start(PAT, 1'b0, l);
        at(l + 30); force_bad = 1'b1;
        at(l + 33); force_bad = 1'b0;
        at(l + 34); chk_status("t4 three bad", 1'b1, 3'd0, 1'b0);
        at(l + 36); chk_status("t4 recovered", 1'b1, 3'd0, 1'b0);
        at(l + 40); force_bad = 1'b1; base = ROT1;
        sq.push_back(l + 45);
        at(l + 43); chk_status("t4 fourth bad", 1'b1, 3'd0, 1'b0);
        at(l + 44); force_bad = 1'b0;
        chk_status("t4 realign", 1'b0, 3'd0, 1'b0);
        check("t4 data_valid0 low", dv0, 1'b0);
        at(l + 66); chk_status("t4 before relock", 1'b0, 3'd1, 1'b0);
        at(l + 67); chk_status("t4 relocked", 1'b1, 3'd1, 1'b0);
        check("t4 slips pending", sq.size(), 0);

        // PLL lock dropped for one cycle in GAP after the second slip.
        start(ROT3, 1'b0, l);
        sq.push_back(l + 12); sq.push_back(l + 18); sq.push_back(l + 32);
        at(l + 19); pll_lock = 1'b0;
        at(l + 20); pll_lock = 1'b1;
        at(l + 21); chk_status("t5 before drop", 1'b0, 3'd2, 1'b0);
        at(l + 22); chk_status("t5 wait_lock", 1'b0, 3'd0, 1'b0);
        at(l + 53); chk_status("t5 before lock", 1'b0, 3'd1, 1'b0);
        at(l + 54); chk_status("t5 aligned", 1'b1, 3'd1, 1'b0);
        check("t5 slips pending", sq.size(), 0);
        at(l + 60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
